operand_alu_ctrl: RTL

//  Downstream consumer of the operand1/operand2 register-file memories. Accepts one

---
 rtl/operand_alu_ctrl_if.sv | 37 +++
 rtl/operand_alu_ctrl.sv | 108 ++++++++++
 2 files changed

// File: rtl/operand_alu_ctrl_if.sv
// Bundle of instruction, operand-memory and result signals for operand_alu_ctrl.
// The master side issues instructions, supplies memory read data and consumes results.
interface operand_alu_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int OP_W   = 3
);
    logic              instr_valid;
    logic              instr_ready;
    logic [OP_W-1:0]   instr_op;
    logic [ADDR_W-1:0] instr_addr1;
    logic [ADDR_W-1:0] instr_addr2;
    logic [ADDR_W-1:0] operand1_addr;
    logic [ADDR_W-1:0] operand2_addr;
    logic [DATA_W-1:0] operand1_value;
    logic [DATA_W-1:0] operand2_value;
    logic              result_valid;
    logic              result_ready;
    logic [DATA_W-1:0] result;
    logic              carry;
    logic              zero;
    logic              busy;

    modport master (
        output instr_valid, instr_op, instr_addr1, instr_addr2,
               operand1_value, operand2_value, result_ready,
        input  instr_ready, operand1_addr, operand2_addr,
               result_valid, result, carry, zero, busy
    );

    modport slave (
        input  instr_valid, instr_op, instr_addr1, instr_addr2,
               operand1_value, operand2_value, result_ready,
        output instr_ready, operand1_addr, operand2_addr,
               result_valid, result, carry, zero, busy
    );
endinterface

// File: rtl/operand_alu_ctrl.sv
// Single-issue operand fetch + ALU controller: accept, wait out the registered
// memory read, execute, then hold the result until the consumer takes it.
module operand_alu_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int OP_W   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    operand_alu_ctrl_if.slave bus
);
    localparam logic [OP_W-1:0] OP_ADD = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB = 3'd1;
    localparam logic [OP_W-1:0] OP_AND = 3'd2;
    localparam logic [OP_W-1:0] OP_OR  = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR = 3'd4;
    localparam logic [OP_W-1:0] OP_NOT = 3'd5;
    localparam logic [OP_W-1:0] OP_SHL = 3'd6;
    localparam logic [OP_W-1:0] OP_SHR = 3'd7;

    typedef enum logic [1:0] {IDLE, WAIT, EXEC, DONE} state_t;

    state_t            state_q, state_d;
    logic [OP_W-1:0]   op_q;
    logic [ADDR_W-1:0] addr1_q, addr2_q;
    logic [DATA_W-1:0] result_q;
    logic              carry_q, zero_q, valid_q;

    logic [DATA_W-1:0] a, b, alu_res;
    logic [DATA_W:0]   sum, diff;
    logic              alu_c;
    logic              accept;

    assign a      = bus.operand1_value;
    assign b      = bus.operand2_value;
    assign accept = (state_q == IDLE) && bus.instr_valid;

    // Bit DATA_W of the widened difference is the unsigned borrow (A < B).
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        case (op_q)
            OP_ADD: begin alu_res = sum[DATA_W-1:0];  alu_c = sum[DATA_W];  end
            OP_SUB: begin alu_res = diff[DATA_W-1:0]; alu_c = diff[DATA_W]; end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_NOT: alu_res = ~a;
            OP_SHL: begin alu_res = {a[DATA_W-2:0], 1'b0}; alu_c = a[DATA_W-1]; end
            OP_SHR: begin alu_res = {1'b0, a[DATA_W-1:1]}; alu_c = a[0];        end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.instr_valid) state_d = WAIT;
            WAIT: state_d = EXEC;
            EXEC: state_d = DONE;
            DONE: if (bus.result_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Addresses stay put after the read so the memories keep presenting the same words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            addr1_q  <= '0;
            addr2_q  <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= bus.instr_op;
                addr1_q <= bus.instr_addr1;
                addr2_q <= bus.instr_addr2;
            end
            if (state_q == EXEC) begin
                result_q <= alu_res;
                carry_q  <= alu_c;
                zero_q   <= (alu_res == '0);
                valid_q  <= 1'b1;
            end
            if (state_q == DONE && bus.result_ready) valid_q <= 1'b0;
        end
    end

    assign bus.instr_ready   = (state_q == IDLE);
    assign bus.busy          = (state_q != IDLE);
    assign bus.operand1_addr = addr1_q;
    assign bus.operand2_addr = addr2_q;
    assign bus.result        = result_q;
    assign bus.carry         = carry_q;
    assign bus.zero          = zero_q;
    assign bus.result_valid  = valid_q;
endmodule
